// File: rtl/fifo_rd_ptr_ctrl.sv
// fifo_rd_ptr_ctrl: read-side pointer, level and flag controller for an async FIFO
module fifo_rd_ptr_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int AE_THRESH   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   wr_ptr_gray_async,
  input  logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              underflow
);
  localparam logic [ADDR_W:0] AE = (ADDR_W+1)'(AE_THRESH);
  logic [ADDR_W:0] sync_q [SYNC_STAGES];
  logic [ADDR_W:0] rd_bin, rd_bin_nxt, wg_s, wb_s, lvl_nxt;
  logic            acc;
  assign wg_s    = sync_q[SYNC_STAGES-1];
  assign rd_addr = rd_bin[ADDR_W-1:0];
  // Gray->binary of the synchronized write pointer, next read pointer and next level
  always_comb begin
    for (int i = 0; i <= ADDR_W; i++) wb_s[i] = ^(wg_s >> i);
    acc        = rd_en & ~empty;
    rd_bin_nxt = acc ? rd_bin + 1'b1 : rd_bin;
    lvl_nxt    = wb_s - rd_bin_nxt;
  end
  // All read-domain state: synchronizer chain, pointers, level and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      rd_bin       <= '0;
      rd_ptr_gray  <= '0;
      rd_level     <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      underflow    <= 1'b0;
    end else begin
      sync_q[0] <= wr_ptr_gray_async;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      rd_bin       <= rd_bin_nxt;
      rd_ptr_gray  <= rd_bin_nxt ^ (rd_bin_nxt >> 1);
      rd_level     <= lvl_nxt;
      empty        <= (lvl_nxt == '0);
      almost_empty <= (lvl_nxt <= AE);
      underflow    <= rd_en & empty;
    end
  end
endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// tb_fifo_rd_ptr_ctrl: directed and random checks of the read-side controller against a count model
module tb_fifo_rd_ptr_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_en = 1'b0;
  logic [4:0] wr_b = '0;
  logic [4:0] wr_g;
  logic [3:0] rd_addr;
  logic [4:0] rd_ptr_gray, rd_level;
  logic       empty, almost_empty, underflow;
  int         n_tests = 0, n_fail = 0;
  logic [4:0] rd_m = '0, s1 = '0, s2 = '0, lvl = '0, gap;
  logic       emp = 1'b1, und = 1'b0;

  assign wr_g = wr_b ^ (wr_b >> 1);

  fifo_rd_ptr_ctrl #(.ADDR_W(4), .AE_THRESH(2), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_ptr_gray_async(wr_g), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_ptr_gray(rd_ptr_gray), .empty(empty),
    .almost_empty(almost_empty), .rd_level(rd_level), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    rd_m = '0; s1 = '0; s2 = '0; lvl = '0; emp = 1'b1; und = 1'b0;
  endtask

  task automatic check_all();
    chk("level", rd_level, lvl);
    chk("empty", empty, emp);
    chk("almost_empty", almost_empty, lvl <= 2);
    chk("underflow", underflow, und);
    chk("rd_addr", rd_addr, rd_m[3:0]);
    chk("rd_ptr_gray", rd_ptr_gray, rd_m ^ (rd_m >> 1));
  endtask

  task automatic step();
    @(posedge clk);
    und  = rd_en && emp;
    rd_m = rd_m + 5'(rd_en && !emp);
    lvl  = s2 - rd_m;
    emp  = (lvl == 0);
    s2   = s1;
    s1   = wr_b;
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_all();
    wr_b = 5;
    steps(4);
    chk("t1_level5", rd_level, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_empty", empty, 1);
    chk("t1_rst_ae", almost_empty, 1);
    chk("t1_rst_level", rd_level, 0);
    chk("t1_rst_gray", rd_ptr_gray, 0);
    chk("t1_rst_addr", rd_addr, 0);
    model_reset();
    wr_b = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wr_b = 1;
    steps(2);
    chk("t2_still_empty", empty, 1);
    step();
    chk("t2_empty_falls", empty, 0);
    chk("t2_level1", rd_level, 1);
    chk("t2_ae", almost_empty, 1);
    #2 rst_n = 1'b0;
    model_reset();
    wr_b = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wr_b = 16;
    steps(3);
    chk("t3_level16", rd_level, 16);
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_addr_seq", rd_addr, i);
      step();
    end
    rd_en = 1'b0;
    chk("t3_empty", empty, 1);
    chk("t3_gray", rd_ptr_gray, 5'b11000);
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_underflow", underflow, 1);
      chk("t4_addr_held", rd_addr, 0);
      chk("t4_gray_held", rd_ptr_gray, 5'b11000);
    end
    rd_en = 1'b0;
    step();
    chk("t4_underflow_drop", underflow, 0);
    wr_b = 31;
    steps(3);
    rd_en = 1'b1;
    steps(15);
    rd_en = 1'b0;
    chk("t5_gray31", rd_ptr_gray, 5'b10000);
    wr_b = 0;
    steps(3);
    chk("t5_level1", rd_level, 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t5_wrap_gray", rd_ptr_gray, 0);
    chk("t5_wrap_addr", rd_addr, 0);
    chk("t5_wrap_empty", empty, 1);
    wr_b = 3;
    steps(3);
    chk("t6_ae0", almost_empty, 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t6_ae1", almost_empty, 1);
    wr_b = 4;
    steps(3);
    chk("t6_level3", rd_level, 3);
    wr_b = 5;
    steps(2);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t6_rw_level", rd_level, 3);
    chk("t6_rw_ae", almost_empty, 0);
    chk("t6_rw_empty", empty, 0);
    for (int i = 0; i < 500; i++) begin
      rd_en = 1'($urandom_range(0, 1));
      gap = wr_b - rd_m;
      if (gap < 16 && $urandom_range(0, 2) != 0) wr_b = wr_b + 1;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule
